// File: rtl/register_file_multiport.sv
// Multi-read-port register file with an integrated busy-bit scoreboard for
// read-after-write hazard detection between decode and writeback.
module register_file_multiport #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_address,
  input  logic                             flush,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_busy,
  output logic [ADDR_WIDTH:0]              busy_count
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  write_ok;
  logic                  reserve_ok;

  // An address is live when implemented and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < (ADDR_WIDTH+1)'(NUM_REGS)) &&
           !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign write_ok   = write_enable   && addr_ok(write_address);
  assign reserve_ok = reserve_enable && addr_ok(reserve_address);

  // Reserve is applied after the write clear so a newer producer keeps the bit.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (write_ok && (write_address == ADDR_WIDTH'(r)))
          busy_next[r] = 1'b0;
        if (reserve_ok && (reserve_address == ADDR_WIDTH'(r)))
          busy_next[r] = 1'b1;
      end
    end
  end

  always_comb begin
    count_next = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      count_next = count_next + (ADDR_WIDTH+1)'(busy_next[r]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (write_ok && (write_address == ADDR_WIDTH'(r)))
          regs[r] <= write_data;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  hit_busy;

    assign addr = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

    // A bypass hit means the producer completes this cycle, so busy is masked.
    always_comb begin
      data     = '0;
      hit_busy = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (addr == ADDR_WIDTH'(r)) begin
          data     = regs[r];
          hit_busy = busy[r];
        end
      end
      if (!addr_ok(addr)) begin
        data     = '0;
        hit_busy = 1'b0;
      end else if ((BYPASS != 0) && write_ok && (addr == write_address)) begin
        data     = write_data;
        hit_busy = 1'b0;
      end
    end

    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign read_busy[p]                          = hit_busy;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport: three configurations driven by shared
// stimulus, checked against directed constants and an array-based model.
module tb_register_file_multiport;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [4:0]  write_address = '0;
  logic [31:0] write_data = '0;
  logic        reserve_enable = 1'b0;
  logic [4:0]  reserve_address = '0;
  logic        flush = 1'b0;
  logic [19:0] read_address = '0;

  logic [63:0]  rdata0, rdata1;
  logic [127:0] rdata2;
  logic [1:0]   rb0, rb1;
  logic [3:0]   rb2;
  logic [5:0]   cnt0, cnt1, cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // k=0: defaults; k=1: no zero register, no bypass; k=2: 24 regs, 4 ports.
  register_file_multiport u_dut0 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .flush(flush), .read_address(read_address[9:0]), .read_data(rdata0),
    .read_busy(rb0), .busy_count(cnt0));

  register_file_multiport #(.ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .flush(flush), .read_address(read_address[9:0]), .read_data(rdata1),
    .read_busy(rb1), .busy_count(cnt1));

  register_file_multiport #(.NUM_REGS(24), .READ_PORTS(4)) u_dut2 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .flush(flush), .read_address(read_address), .read_data(rdata2),
    .read_busy(rb2), .busy_count(cnt2));

  function automatic int nr(input int k); return (k == 2) ? 24 : 32; endfunction
  function automatic bit zr(input int k); return k != 1; endfunction
  function automatic bit bp(input int k); return k != 1; endfunction
  function automatic int rp(input int k); return (k == 2) ? 4 : 2; endfunction

  function automatic logic [31:0] get_data(input int k, input int p);
    case (k)
      0:       return rdata0[p*32 +: 32];
      1:       return rdata1[p*32 +: 32];
      default: return rdata2[p*32 +: 32];
    endcase
  endfunction

  function automatic logic get_busy(input int k, input int p);
    case (k)
      0:       return rb0[p];
      1:       return rb1[p];
      default: return rb2[p];
    endcase
  endfunction

  function automatic logic [5:0] get_cnt(input int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  // Reference model: plain arrays updated from the architectural rules.
  logic [31:0] m_regs [3][32];
  bit          m_busy [3][32];

  function automatic bit m_ok(input int k, input logic [4:0] a);
    return (int'(a) < nr(k)) && !(zr(k) && (a == 5'd0));
  endfunction

  function automatic bit m_bypass(input int k, input logic [4:0] a);
    return bp(k) && write_enable && m_ok(k, write_address) && (a == write_address);
  endfunction

  function automatic logic [31:0] exp_data(input int k, input logic [4:0] a);
    if (!m_ok(k, a)) return 32'd0;
    if (m_bypass(k, a)) return write_data;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] a);
    if (!m_ok(k, a) || m_bypass(k, a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [5:0] exp_cnt(input int k);
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[k][r]);
    return 6'(c);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++)
        for (int r = 0; r < 32; r++) begin
          m_regs[k][r] <= '0;
          m_busy[k][r] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (write_enable && m_ok(k, write_address)) begin
          m_regs[k][write_address] <= write_data;
          m_busy[k][write_address] <= 1'b0;
        end
        if (flush) begin
          for (int r = 0; r < 32; r++) m_busy[k][r] <= 1'b0;
        end else if (reserve_enable && m_ok(k, reserve_address)) begin
          m_busy[k][reserve_address] <= 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_address = {4{5'(a)}};
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < rp(k); p++) begin
          n_cmp++;
          if (get_data(k, p) !== 32'd0) begin
            n_fail++; $display("FAIL reset_data dut%0d port%0d addr%0d: got %h want 0", k, p, a, get_data(k, p));
          end
          n_cmp++;
          if (get_busy(k, p) !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy dut%0d port%0d addr%0d: got %b want 0", k, p, a, get_busy(k, p));
          end
        end
        n_cmp++;
        if (get_cnt(k) !== 6'd0) begin
          n_fail++; $display("FAIL reset_count dut%0d: got %0d want 0", k, get_cnt(k));
        end
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF;
    read_address = {4{5'd5}};
    #1;
    n_cmp++;
    if (rdata0[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rdata0[63:32]);
    end
    n_cmp++;
    if (rdata1[63:32] !== 32'd0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h want 0", rdata1[63:32]);
    end
    @(negedge clock);
    write_enable = 1'b0;
    #1;
    n_cmp++;
    if (rdata1[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL nobypass_next_cycle: got %h want deadbeef", rdata1[63:32]);
    end
    n_cmp++;
    if (rdata0[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h want deadbeef", rdata0[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd0; write_data = 32'h12345678;
    reserve_enable = 1'b1; reserve_address = 5'd0;
    read_address = '0;
    #1;
    n_cmp++;
    if (rdata0[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL zero_bypass: got %h want 0", rdata0[31:0]);
    end
    @(negedge clock);
    write_enable = 1'b0; reserve_enable = 1'b0;
    #1;
    n_cmp++;
    if (rdata0[31:0] !== 32'd0 || rb0[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_read: got data %h busy %b want 0/0", rdata0[31:0], rb0[0]);
    end
    n_cmp++;
    if (cnt0 !== 6'd0 || cnt2 !== 6'd0) begin
      n_fail++; $display("FAIL zero_count: got %0d/%0d want 0/0", cnt0, cnt2);
    end
    n_cmp++;
    if (rdata1[31:0] !== 32'h12345678 || rb1[0] !== 1'b1 || cnt1 !== 6'd1) begin
      n_fail++; $display("FAIL r0_plain: got data %h busy %b count %0d want 12345678/1/1", rdata1[31:0], rb1[0], cnt1);
    end
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    n_cmp++;
    if (cnt1 !== 6'd0) begin
      n_fail++; $display("FAIL r0_flush_count: got %0d want 0", cnt1);
    end
  endtask

  task automatic test_reserve_write_collision();
    @(negedge clock);
    reserve_enable = 1'b1; reserve_address = 5'd3;
    read_address = {4{5'd3}};
    #1;
    n_cmp++;
    if (rb0[0] !== 1'b0) begin
      n_fail++; $display("FAIL reserve_same_cycle_busy: got %b want 0", rb0[0]);
    end
    @(negedge clock);
    reserve_enable = 1'b0;
    #1;
    n_cmp++;
    if (rb0[0] !== 1'b1 || cnt0 !== 6'd1) begin
      n_fail++; $display("FAIL reserve_latency: got busy %b count %0d want 1/1", rb0[0], cnt0);
    end
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd3; write_data = 32'h55;
    reserve_enable = 1'b1; reserve_address = 5'd3;
    #1;
    n_cmp++;
    if (rb0[0] !== 1'b0 || rdata0[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL collide_bypass: got busy %b data %h want 0/55", rb0[0], rdata0[31:0]);
    end
    n_cmp++;
    if (rb1[0] !== 1'b1) begin
      n_fail++; $display("FAIL collide_nobypass_busy: got %b want 1", rb1[0]);
    end
    @(negedge clock);
    write_enable = 1'b0; reserve_enable = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_busy(k, 0) !== 1'b1 || get_data(k, 0) !== 32'h55 || get_cnt(k) !== 6'd1) begin
        n_fail++; $display("FAIL collide_after dut%0d: got busy %b data %h count %0d want 1/55/1", k, get_busy(k, 0), get_data(k, 0), get_cnt(k));
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    reserve_enable = 1'b1; reserve_address = 5'd1;
    @(negedge clock);
    reserve_address = 5'd2;
    @(negedge clock);
    reserve_address = 5'd7;
    @(negedge clock);
    flush = 1'b1; reserve_address = 5'd9;
    #1;
    n_cmp++;
    if (cnt0 !== 6'd3 || cnt2 !== 6'd3) begin
      n_fail++; $display("FAIL flush_precount: got %0d/%0d want 3/3", cnt0, cnt2);
    end
    @(negedge clock);
    flush = 1'b0; reserve_enable = 1'b0;
    read_address = {5'd7, 5'd2, 5'd1, 5'd9};
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_cnt(k) !== 6'd0 || get_busy(k, 0) !== 1'b0 || get_busy(k, 1) !== 1'b0) begin
        n_fail++; $display("FAIL flush_after dut%0d: got count %0d busy9 %b busy1 %b want 0/0/0", k, get_cnt(k), get_busy(k, 0), get_busy(k, 1));
      end
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd30; write_data = 32'hA5A5A5A5;
    reserve_enable = 1'b1; reserve_address = 5'd30;
    read_address = {4{5'd30}};
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (rdata2[p*32 +: 32] !== 32'd0 || rb2[p] !== 1'b0) begin
        n_fail++; $display("FAIL oor_same_cycle port%0d: got %h/%b want 0/0", p, rdata2[p*32 +: 32], rb2[p]);
      end
    end
    @(negedge clock);
    write_enable = 1'b0; reserve_enable = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (rdata2[p*32 +: 32] !== 32'd0 || rb2[p] !== 1'b0) begin
        n_fail++; $display("FAIL oor_next_cycle port%0d: got %h/%b want 0/0", p, rdata2[p*32 +: 32], rb2[p]);
      end
    end
    n_cmp++;
    if (cnt2 !== 6'd0 || cnt0 !== 6'd1 || rdata0[31:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL oor_counts: got cnt2 %0d cnt0 %0d data0 %h want 0/1/a5a5a5a5", cnt2, cnt0, rdata0[31:0]);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd12; write_data = 32'hCAFEF00D;
    reserve_enable = 1'b1; reserve_address = 5'd12;
    read_address = {5'd12, 5'd3, 5'd30, 5'd5};
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; write_enable = 1'b0; reserve_enable = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < rp(k); p++) begin
        n_cmp++;
        if (get_data(k, p) !== 32'd0 || get_busy(k, p) !== 1'b0) begin
          n_fail++; $display("FAIL reset_mid dut%0d port%0d: got %h/%b want 0/0", k, p, get_data(k, p), get_busy(k, p));
        end
      end
      n_cmp++;
      if (get_cnt(k) !== 6'd0) begin
        n_fail++; $display("FAIL reset_mid_count dut%0d: got %0d want 0", k, get_cnt(k));
      end
    end
  endtask

  task automatic test_random(input int cycles);
    logic [4:0] a;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      write_enable    = 1'($urandom_range(0, 1));
      write_address   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      write_data      = $urandom;
      reserve_enable  = 1'($urandom_range(0, 1));
      reserve_address = ($urandom_range(0, 2) == 0) ? write_address : 5'($urandom_range(0, 31));
      flush           = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 4; p++)
        read_address[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < rp(k); p++) begin
          a = read_address[p*5 +: 5];
          n_cmp++;
          if (get_data(k, p) !== exp_data(k, a)) begin
            n_fail++; $display("FAIL rand_data dut%0d port%0d addr%0d: got %h want %h", k, p, a, get_data(k, p), exp_data(k, a));
          end
          n_cmp++;
          if (get_busy(k, p) !== exp_busy(k, a)) begin
            n_fail++; $display("FAIL rand_busy dut%0d port%0d addr%0d: got %b want %b", k, p, a, get_busy(k, p), exp_busy(k, a));
          end
        end
        n_cmp++;
        if (get_cnt(k) !== exp_cnt(k)) begin
          n_fail++; $display("FAIL rand_count dut%0d: got %0d want %0d", k, get_cnt(k), exp_cnt(k));
        end
      end
    end
    @(negedge clock);
    write_enable = 1'b0; reserve_enable = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve_write_collision();
    test_flush();
    test_out_of_range();
    test_reset_mid_write();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_multiport.md
# register_file_multiport

Parametrised general-purpose register file for the Risky core with a configurable number of read ports, an optional hardwired zero register and an optional write-to-read bypass. It also has an integrated busy-bit scoreboard that the decode stage uses to detect read-after-write hazards. It sits between decode (reads, reservations) and writeback (writes), and replaces the fixed two-read-port register file.

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of implemented registers; must be ≤ 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports; must be ≥ 1
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all registers and busy bits
- write_enable  input  1  writeback write strobe
- write_address  input  ADDR_WIDTH  writeback destination
- write_data  input  DATA_WIDTH  writeback value
- reserve_enable  input  1  decode marks a destination as pending
- reserve_address  input  ADDR_WIDTH  register being reserved
- flush  input  1  synchronous clear of all busy bits (pipeline flush)
- read_address  input  READ_PORTS*ADDR_WIDTH  packed; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  output  READ_PORTS*DATA_WIDTH  packed, same ordering as read_address
- read_busy  output  READ_PORTS  per-port: the addressed register has an outstanding producer
- busy_count  output  ADDR_WIDTH+1  number of busy bits currently set

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops plus NUM_REGS busy flops; all reset to 0 asynchronously.
- Write: on a clock edge with write_enable=1, registers[write_address] ← write_data.
  - Ignored if write_address ≥ NUM_REGS.
  - Ignored if ZERO_REG=1 and write_address=0.
- Write clears busy: the same edge clears busy[write_address].
- Reserve: on a clock edge with reserve_enable=1, busy[reserve_address] ← 1. Ignored under the same address conditions as a write.
- Write and reserve to the same address in one cycle: reserve wins, busy stays/becomes 1, and the data is still written (a newer producer has issued).
- Flush: flush=1 clears all busy bits at the edge.
  - Flush has priority over reserve; a reserve in the flush cycle is dropped.
  - A write in the flush cycle still updates data.
- Reads: combinational per port.
  - read_data = registers[addr]; 0 if addr ≥ NUM_REGS or (ZERO_REG and addr=0).
  - If BYPASS=1, write_enable=1, addr=write_address and the write is not ignored, then read_data = write_data.
  - read_busy = busy[addr], forced 0 when the bypass hits (that producer has completed) and forced 0 for ignored/zero addresses.
- busy_count: registered popcount of the busy vector, updated on the same edge as the busy bits. Range 0..NUM_REGS.

## Timing
- Reset values: read_data all 0, read_busy all 0, busy_count 0. Reset mid-operation discards pending writes and reservations immediately.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0.
- Reserve-to-busy latency: 1 cycle; read_busy is not asserted in the reserve cycle itself.
- Write clears busy: visible on read_busy in the same cycle via bypass (BYPASS=1), otherwise 1 cycle later.
- Flush effect is visible 1 cycle after the flush cycle; busy_count reads 0 on that cycle unless a reservation follows.
- All READ_PORTS ports are independent; any number may address the same register.

## Test plan
- Reset, then read all addresses on every port -> read_data=0, read_busy=0, busy_count=0.
- Write 0xDEADBEEF to r5 with read port 1 addressing r5 in the same cycle -> BYPASS=1: port 1 shows 0xDEADBEEF that cycle; BYPASS=0: port 1 shows 0 that cycle and 0xDEADBEEF next cycle.
- Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0; reserve r0 -> read_busy stays 0 and busy_count stays 0.
- Reserve r3, then two cycles later write r3=0x55 with reserve r3 in the same cycle -> read_busy[r3] stays 1, data reads 0x55, busy_count stays 1.
- Reserve r1, r2, r7 in consecutive cycles -> busy_count=3; assert flush together with reserve r9 -> next cycle busy_count=0 and r9 not busy.
- Configure READ_PORTS=4, NUM_REGS=24 and read r30 on all ports after writing r30 -> read_data=0, read_busy=0; assert reset mid-write -> all outputs 0 on the following cycle.
